// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and widths for the instruction-memory loader.
//               State encoding, byte/word geometry and address width.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;
    localparam int ADDR_W         = 64;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module      : imem_byte_assembler
// Description : Collects four bytes, little-endian (first byte -> bits 7:0),
//               into a 32-bit word. word_valid pulses combinationally in the
//               cycle the 4th byte is accepted, with word already complete.
// Ports       : clk, reset (async, active-high)
//               clear      - synchronous discard of any partial word
//               accept     - byte_in is taken on this rising edge
//               byte_in    - stream byte
//               word_valid - 4th byte being accepted this cycle
//               word       - assembled word (valid with word_valid)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_byte_assembler
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               accept,
    input  logic [7:0]         byte_in,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    logic [1:0]  byte_cnt;
    // Only the first three bytes need storage; the 4th is taken straight
    // from byte_in so the word is available in its accepting cycle.
    logic [23:0] shift;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
        end else if (clear) begin
            byte_cnt <= 2'd0;
            shift    <= 24'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {byte_in, shift[23:8]};
        end
    end

    assign word_valid = accept && !clear && (byte_cnt == 2'd3);
    assign word       = {byte_in, shift};

endmodule : imem_byte_assembler
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a program as a byte stream (4-byte LE count N, then
//               N LE words) and writes the words to instruction memory at
//               BASE_ADDR, +4, +8 ... Holds the core in reset until done.
//               Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Ports       : clk, reset (async, active-high), start (restart from DONE/ERR)
//               in_valid/in_data/in_ready  - byte stream handshake
//               mem_we/mem_addr/mem_wdata  - instruction memory write port
//               cpu_hold, done, error, words_loaded - status
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 64'd0,
    parameter int                MAX_WORDS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [15:0]        words_loaded
);

    localparam logic [31:0] MAX_N = 32'(MAX_WORDS);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_LOAD = CSUM;
`else
    localparam state_t AFTER_LOAD = DONE;
`endif

    state_t             state;
    state_t             state_next;
    logic [31:0]        hdr_count;
    logic               accept;
    logic               asm_accept;
    logic               restart;
    logic               word_valid;
    logic [INSTR_W-1:0] word;
    logic               last_word;

    assign accept     = in_valid && in_ready;
    assign asm_accept = accept && ((state == HDR) || (state == DATA));
    assign restart    = start && ((state == DONE) || (state == ERR));
    assign last_word  = (({16'd0, words_loaded} + 32'd1) == hdr_count);

    imem_byte_assembler u_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (restart),
        .accept     (asm_accept),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] csum;

    // Running XOR of every header and data byte.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum <= 8'd0;
        end else if (restart) begin
            csum <= 8'd0;
        end else if (asm_accept) begin
            csum <= csum ^ in_data;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= HDR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            HDR: begin
                if (word_valid) begin
                    if (word == 32'd0) begin
                        state_next = AFTER_LOAD;
                    end else if (word > MAX_N) begin
                        state_next = ERR;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid && last_word) begin
                    state_next = AFTER_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    state_next = (in_data == csum) ? DONE : ERR;
                end
            end
`endif
            DONE, ERR: begin
                if (start) begin
                    state_next = HDR;
                end
            end
            default: state_next = HDR;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        in_ready = (state == HDR) || (state == DATA) || (state == CSUM);
        done     = (state == DONE);
        error    = (state == ERR);
        cpu_hold = (state != DONE);
    end

    // Header capture and memory write datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_count    <= 32'd0;
            words_loaded <= 16'd0;
            mem_we       <= 1'b0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (restart) begin
                words_loaded <= 16'd0;
            end
            if ((state == HDR) && word_valid) begin
                hdr_count <= word;
            end
            if ((state == DATA) && word_valid) begin
                mem_we       <= 1'b1;
                mem_addr     <= BASE_ADDR + {46'd0, words_loaded, 2'b00};
                mem_wdata    <= word;
                words_loaded <= words_loaded + 16'd1;
            end
        end
    end

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int total = 0;
    int bad   = 0;

    // Write log filled by a negedge monitor.
    int          wr_cnt = 0;
    logic [63:0] wr_addr [0:31];
    logic [31:0] wr_data [0:31];

    imem_loader #(.BASE_ADDR(64'd0), .MAX_WORDS(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one byte for exactly one accepting edge; returns at edge + 1.
    task automatic send_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(2);
        #2 reset = 1'b0;
        idle(1);
        total++;
        if ({in_ready, mem_we, cpu_hold, done, error} !== 5'b10100) begin
            bad++;
            $display("FAIL reset_flags: got ready/we/hold/done/err=%b want 10100",
                     {in_ready, mem_we, cpu_hold, done, error});
        end
        total++;
        if (mem_addr !== 64'd0 || mem_wdata !== 32'd0 || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL reset_regs: got addr=%h wdata=%h wl=%0d want 0/0/0",
                     mem_addr, mem_wdata, words_loaded);
        end
    endtask

    task automatic test_basic;
        wr_cnt = 0;
        send_word(32'd2);
        send_word(32'h0000_3083);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 64'd0 || mem_wdata !== 32'h0000_3083) begin
            bad++;
            $display("FAIL basic_w0: got we=%b addr=%h data=%h want 1/0/00003083",
                     mem_we, mem_addr, mem_wdata);
        end
        send_word(32'h0000_B983);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 64'd4 || mem_wdata !== 32'h0000_B983
            || words_loaded !== 16'd2) begin
            bad++;
            $display("FAIL basic_w1: got we=%b addr=%h data=%h wl=%0d want 1/4/0000b983/2",
                     mem_we, mem_addr, mem_wdata, words_loaded);
        end
        idle(1);
        total++;
        if ({mem_we, done, cpu_hold, in_ready, error} !== 5'b01000) begin
            bad++;
            $display("FAIL basic_done: got we/done/hold/ready/err=%b want 01000",
                     {mem_we, done, cpu_hold, in_ready, error});
        end
        total++;
        if (wr_cnt !== 2 || wr_addr[0] !== 64'd0 || wr_data[0] !== 32'h0000_3083
            || wr_addr[1] !== 64'd4 || wr_data[1] !== 32'h0000_B983) begin
            bad++;
            $display("FAIL basic_log: got cnt=%0d a0=%h d0=%h a1=%h d1=%h want 2/0/3083/4/b983",
                     wr_cnt, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
        end
        pulse_start;
        total++;
        if ({done, error, cpu_hold, in_ready} !== 4'b0011 || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL basic_restart: got done/err/hold/ready=%b wl=%0d want 0011/0",
                     {done, error, cpu_hold, in_ready}, words_loaded);
        end
    endtask

    task automatic test_zero_count;
        wr_cnt = 0;
        send_word(32'd0);
        total++;
        if ({done, cpu_hold, in_ready} !== 3'b100 || words_loaded !== 16'd0) begin
            bad++;
            $display("FAIL zero_done: got done/hold/ready=%b wl=%0d want 100/0",
                     {done, cpu_hold, in_ready}, words_loaded);
        end
        idle(3);
        total++;
        if (wr_cnt !== 0) begin
            bad++;
            $display("FAIL zero_nowrite: got writes=%0d want 0", wr_cnt);
        end
        pulse_start;
    endtask

    task automatic test_overflow;
        wr_cnt = 0;
        send_word(32'd17);
        total++;
        if ({error, cpu_hold, in_ready, done} !== 4'b1100) begin
            bad++;
            $display("FAIL over_err: got err/hold/ready/done=%b want 1100",
                     {error, cpu_hold, in_ready, done});
        end
        // Bytes offered while in ERR must not be taken.
        send_word(32'hFFFF_FFFF);
        total++;
        if (wr_cnt !== 0 || error !== 1'b1) begin
            bad++;
            $display("FAIL over_nowrite: got writes=%0d err=%b want 0/1", wr_cnt, error);
        end
        pulse_start;
        total++;
        if ({error, in_ready, cpu_hold} !== 3'b011) begin
            bad++;
            $display("FAIL over_restart: got err/ready/hold=%b want 011",
                     {error, in_ready, cpu_hold});
        end
        // N == MAX_WORDS is the largest legal count: stays receptive, no error.
        send_word(32'd16);
        total++;
        if ({error, in_ready, done} !== 3'b010) begin
            bad++;
            $display("FAIL max_ok: got err/ready/done=%b want 010", {error, in_ready, done});
        end
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        idle(1);
    endtask

    task automatic test_gaps;
        logic [31:0] w;
        w = 32'hDEAD_BEEF;
        wr_cnt = 0;
        send_byte(8'h01); idle(1);
        send_byte(8'h00); idle(1);
        send_byte(8'h00); idle(1);
        send_byte(8'h00); idle(1);
        send_byte(w[7:0]);   idle(1);
        send_byte(w[15:8]);  idle(10);
        send_byte(w[23:16]); idle(1);
        total++;
        if (wr_cnt !== 0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL gap_early: got writes=%0d we=%b want 0/0", wr_cnt, mem_we);
        end
        send_byte(w[31:24]);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 64'd0 || mem_wdata !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL gap_write: got we=%b addr=%h data=%h want 1/0/deadbeef",
                     mem_we, mem_addr, mem_wdata);
        end
        idle(1);
        total++;
        if (mem_we !== 1'b0 || done !== 1'b1 || wr_cnt !== 1) begin
            bad++;
            $display("FAIL gap_done: got we=%b done=%b writes=%0d want 0/1/1",
                     mem_we, done, wr_cnt);
        end
        pulse_start;
    endtask

    task automatic test_reset_mid;
        wr_cnt = 0;
        send_word(32'd3);
        send_word(32'hAAAA_5555);
        send_byte(8'h11);
        send_byte(8'h22);
        #2 reset = 1'b1;
        #1;
        total++;
        if (words_loaded !== 16'd0 || mem_wdata !== 32'd0 || mem_addr !== 64'd0
            || {mem_we, in_ready, cpu_hold, done, error} !== 5'b01100) begin
            bad++;
            $display("FAIL midreset_vals: got wl=%0d wdata=%h addr=%h flags=%b want 0/0/0/01100",
                     words_loaded, mem_wdata, mem_addr,
                     {mem_we, in_ready, cpu_hold, done, error});
        end
        #1 reset = 1'b0;
        idle(1);
        wr_cnt = 0;
        send_word(32'd1);
        send_word(32'h1234_5678);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 64'd0 || mem_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL midreset_reload: got we=%b addr=%h data=%h want 1/0/12345678",
                     mem_we, mem_addr, mem_wdata);
        end
        idle(1);
        total++;
        if (done !== 1'b1 || words_loaded !== 16'd1 || wr_cnt !== 1) begin
            bad++;
            $display("FAIL midreset_done: got done=%b wl=%0d writes=%0d want 1/1/1",
                     done, words_loaded, wr_cnt);
        end
        pulse_start;
    endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Stream bytes 01 00 00 00 33 05 00 00: XOR = 01^33^05 = 8'h37.
    task automatic test_checksum;
        wr_cnt = 0;
        send_word(32'd1);
        send_word(32'h0000_0533);
        total++;
        if (mem_we !== 1'b1 || mem_addr !== 64'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL csum_wait: got we=%b addr=%h done=%b ready=%b want 1/0/0/1",
                     mem_we, mem_addr, done, in_ready);
        end
        send_byte(8'h37);
        total++;
        if ({done, error, cpu_hold} !== 3'b100) begin
            bad++;
            $display("FAIL csum_good: got done/err/hold=%b want 100", {done, error, cpu_hold});
        end
        pulse_start;
        wr_cnt = 0;
        send_word(32'd1);
        send_word(32'h0000_0533);
        send_byte(8'h66);
        total++;
        if ({done, error, cpu_hold, in_ready} !== 4'b0110 || wr_cnt !== 1) begin
            bad++;
            $display("FAIL csum_bad: got done/err/hold/ready=%b writes=%0d want 0110/1",
                     {done, error, cpu_hold, in_ready}, wr_cnt);
        end
        pulse_start;
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_zero_count;
        test_overflow;
        test_gaps;
        test_reset_mid;
`ifdef IMEM_LOADER_CHECKSUM_EN
        test_checksum;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
